// File: rtl/can_tx_sched_pkg.sv
// Shared CAN transmit definitions: field widths, scheduler states and DLC clamp.
package can_tx_sched_pkg;
  localparam int CAN_ID_W   = 11;
  localparam int CAN_DLC_W  = 4;
  localparam int CAN_DATA_W = 64;
  localparam logic [CAN_DLC_W-1:0] DLC_MAX = 4'd8;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ARB,
    ST_WAIT_IFS,
    ST_LAUNCH,
    ST_BUSY
  } state_t;

  function automatic logic [CAN_DLC_W-1:0] clamp_dlc(input logic [CAN_DLC_W-1:0] dlc);
    return (dlc > DLC_MAX) ? DLC_MAX : dlc;
  endfunction
endpackage

// File: rtl/can_tx_sched_if.sv
// Mailbox write, abort, transmitter handshake and status signals of the scheduler.
interface can_tx_sched_if #(
  parameter int NUM_MB = 4
);
  localparam int IDX_W = (NUM_MB > 1) ? $clog2(NUM_MB) : 1;

  logic              i_Wr_En;
  logic [IDX_W-1:0]  i_Wr_Idx;
  logic [10:0]       i_Wr_Id;
  logic [3:0]        i_Wr_Dlc;
  logic [63:0]       i_Wr_Data;
  logic [NUM_MB-1:0] i_Abort;
  logic              i_Bus_Idle;
  logic              i_Tx_Done;
  logic              i_Tx_Arb_Lost;
  logic              i_Tx_Error;
  logic              o_Tx_DV;
  logic [10:0]       o_Tx_Id;
  logic [3:0]        o_Tx_Dlc;
  logic [63:0]       o_Tx_Data;
  logic [NUM_MB-1:0] o_Mb_Pending;
  logic [NUM_MB-1:0] o_Mb_Done;
  logic [NUM_MB-1:0] o_Mb_Fail;
  logic              o_Wr_Err;

  modport master (
    output i_Wr_En, i_Wr_Idx, i_Wr_Id, i_Wr_Dlc, i_Wr_Data, i_Abort,
           i_Bus_Idle, i_Tx_Done, i_Tx_Arb_Lost, i_Tx_Error,
    input  o_Tx_DV, o_Tx_Id, o_Tx_Dlc, o_Tx_Data, o_Mb_Pending,
           o_Mb_Done, o_Mb_Fail, o_Wr_Err
  );

  modport slave (
    input  i_Wr_En, i_Wr_Idx, i_Wr_Id, i_Wr_Dlc, i_Wr_Data, i_Abort,
           i_Bus_Idle, i_Tx_Done, i_Tx_Arb_Lost, i_Tx_Error,
    output o_Tx_DV, o_Tx_Id, o_Tx_Dlc, o_Tx_Data, o_Mb_Pending,
           o_Mb_Done, o_Mb_Fail, o_Wr_Err
  );
endinterface

// File: rtl/can_tx_sched_prio_sel.sv
// Combinational CAN priority select: lowest Id among pending mailboxes, ties to lowest index.
module can_prio_sel
  import can_tx_sched_pkg::*;
#(
  parameter int NUM_MB = 4,
  parameter int IDX_W  = 2
) (
  input  logic [NUM_MB-1:0]          pending,
  input  logic [NUM_MB*CAN_ID_W-1:0] ids,
  output logic [IDX_W-1:0]           idx,
  output logic                       vld
);
  logic [CAN_ID_W-1:0] best;

  // Strict less-than keeps the earlier (lower) index on equal Ids.
  always_comb begin
    idx  = '0;
    vld  = 1'b0;
    best = '1;
    for (int i = 0; i < NUM_MB; i++) begin
      if (pending[i] && (!vld || (ids[i*CAN_ID_W +: CAN_ID_W] < best))) begin
        vld  = 1'b1;
        best = ids[i*CAN_ID_W +: CAN_ID_W];
        idx  = IDX_W'(i);
      end
    end
  end
endmodule

// File: rtl/can_tx_sched.sv
// CAN transmit scheduler: mailbox store, priority arbitration, intermission wait and retry control.
module can_tx_sched
  import can_tx_sched_pkg::*;
#(
  parameter int NUM_MB       = 4,
  parameter int CLKS_PER_BIT = 10,
  parameter int IFS_BITS     = 3,
  parameter int MAX_RETRY    = 8
) (
  input logic          i_Clock,
  input logic          i_Reset,
  can_tx_sched_if.slave bus
);
  localparam int IDX_W   = (NUM_MB > 1) ? $clog2(NUM_MB) : 1;
  localparam int IFS_CNT = IFS_BITS * CLKS_PER_BIT;
  localparam int CNT_W   = $clog2(IFS_CNT + 1);

  logic [CAN_ID_W-1:0]   mb_id   [NUM_MB];
  logic [CAN_DLC_W-1:0]  mb_dlc  [NUM_MB];
  logic [CAN_DATA_W-1:0] mb_data [NUM_MB];
  logic [3:0]            err_cnt [NUM_MB];
  logic [NUM_MB-1:0]     pending;
  state_t                state;
  logic [IDX_W-1:0]      win;
  logic [CNT_W-1:0]      cnt;
  logic                  abort_lat;

  logic [NUM_MB*CAN_ID_W-1:0] ids_flat;
  logic [IDX_W-1:0]           sel_idx;
  logic                       sel_vld;
  logic                       in_flight;
  logic                       tx_active;
  logic                       wr_blocked;
  logic                       wr_ok;
  logic                       abort_eff;

  always_comb begin
    ids_flat = '0;
    for (int i = 0; i < NUM_MB; i++) ids_flat[i*CAN_ID_W +: CAN_ID_W] = mb_id[i];
  end

  can_prio_sel #(.NUM_MB(NUM_MB), .IDX_W(IDX_W)) u_prio_sel (
    .pending (pending),
    .ids     (ids_flat),
    .idx     (sel_idx),
    .vld     (sel_vld)
  );

  // The winner is protected from writes from WAIT_IFS on, but still abortable until launch.
  assign in_flight  = (state == ST_WAIT_IFS) || (state == ST_LAUNCH) || (state == ST_BUSY);
  assign tx_active  = (state == ST_LAUNCH) || (state == ST_BUSY);
  assign wr_blocked = bus.i_Wr_En && in_flight && (bus.i_Wr_Idx == win);
  assign wr_ok      = bus.i_Wr_En && !wr_blocked;
  assign abort_eff  = abort_lat || bus.i_Abort[win];
  assign bus.o_Mb_Pending = pending;

  always_ff @(posedge i_Clock) begin
    if (i_Reset) begin
      state         <= ST_IDLE;
      pending       <= '0;
      win           <= '0;
      cnt           <= '0;
      abort_lat     <= 1'b0;
      bus.o_Tx_DV   <= 1'b0;
      bus.o_Tx_Id   <= '0;
      bus.o_Tx_Dlc  <= '0;
      bus.o_Tx_Data <= '0;
      bus.o_Mb_Done <= '0;
      bus.o_Mb_Fail <= '0;
      bus.o_Wr_Err  <= 1'b0;
      for (int i = 0; i < NUM_MB; i++) err_cnt[i] <= '0;
    end else begin
      bus.o_Tx_DV   <= 1'b0;
      bus.o_Mb_Done <= '0;
      bus.o_Mb_Fail <= '0;
      bus.o_Wr_Err  <= 1'b0;

      for (int i = 0; i < NUM_MB; i++) begin
        if (bus.i_Abort[i] && pending[i] && !(tx_active && (win == IDX_W'(i))) &&
            !(wr_ok && (bus.i_Wr_Idx == IDX_W'(i)))) begin
          pending[i]       <= 1'b0;
          bus.o_Mb_Fail[i] <= 1'b1;
        end
      end

      if (wr_blocked) begin
        bus.o_Wr_Err <= 1'b1;
      end else if (bus.i_Wr_En) begin
        mb_id[bus.i_Wr_Idx]   <= bus.i_Wr_Id;
        mb_dlc[bus.i_Wr_Idx]  <= clamp_dlc(bus.i_Wr_Dlc);
        mb_data[bus.i_Wr_Idx] <= bus.i_Wr_Data;
        err_cnt[bus.i_Wr_Idx] <= '0;
        pending[bus.i_Wr_Idx] <= 1'b1;
      end

      case (state)
        ST_IDLE: if (|pending) state <= ST_ARB;
        ST_ARB: begin
          abort_lat <= 1'b0;
          if (sel_vld) begin
            win   <= sel_idx;
            cnt   <= CNT_W'(IFS_CNT);
            state <= ST_WAIT_IFS;
          end else begin
            state <= ST_IDLE;
          end
        end
        ST_WAIT_IFS: begin
          if (!pending[win] || bus.i_Abort[win]) begin
            state <= ST_IDLE;
          end else if (!bus.i_Bus_Idle) begin
            cnt <= CNT_W'(IFS_CNT);
          end else if (cnt <= CNT_W'(1)) begin
            cnt           <= '0;
            state         <= ST_LAUNCH;
            bus.o_Tx_DV   <= 1'b1;
            bus.o_Tx_Id   <= mb_id[win];
            bus.o_Tx_Dlc  <= mb_dlc[win];
            bus.o_Tx_Data <= mb_data[win];
          end else begin
            cnt <= cnt - CNT_W'(1);
          end
        end
        ST_LAUNCH: begin
          state <= ST_BUSY;
          if (bus.i_Abort[win]) abort_lat <= 1'b1;
        end
        ST_BUSY: begin
          if (bus.i_Tx_Error) begin
            state        <= ST_IDLE;
            err_cnt[win] <= err_cnt[win] + 4'd1;
            if (abort_eff || ((err_cnt[win] + 4'd1) == 4'(MAX_RETRY))) begin
              pending[win]       <= 1'b0;
              bus.o_Mb_Fail[win] <= 1'b1;
            end
          end else if (bus.i_Tx_Arb_Lost) begin
            state <= ST_IDLE;
            if (abort_eff) begin
              pending[win]       <= 1'b0;
              bus.o_Mb_Fail[win] <= 1'b1;
            end
          end else if (bus.i_Tx_Done) begin
            state              <= ST_IDLE;
            pending[win]       <= 1'b0;
            bus.o_Mb_Done[win] <= 1'b1;
          end else if (bus.i_Abort[win]) begin
            abort_lat <= 1'b1;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_can_tx_sched.sv
// Directed bench for can_tx_sched: latency, priority order, IFS reload, retries, aborts, reset.
module tb_can_tx_sched;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks = 0;
  int   errors = 0;

  can_tx_sched_if #(.NUM_MB(4)) bus();

  can_tx_sched #(.NUM_MB(4), .CLKS_PER_BIT(10), .IFS_BITS(3), .MAX_RETRY(8)) dut (
    .i_Clock (clk),
    .i_Reset (rst),
    .bus     (bus)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic write_mb(input logic [1:0] idx, input logic [10:0] id,
                          input logic [3:0] dlc, input logic [63:0] data);
    bus.i_Wr_En   = 1'b1;
    bus.i_Wr_Idx  = idx;
    bus.i_Wr_Id   = id;
    bus.i_Wr_Dlc  = dlc;
    bus.i_Wr_Data = data;
    tick();
    bus.i_Wr_En   = 1'b0;
  endtask

  // kind: 0 done, 1 arbitration lost, 2 error
  task automatic outcome(input int kind);
    bus.i_Tx_Done     = (kind == 0);
    bus.i_Tx_Arb_Lost = (kind == 1);
    bus.i_Tx_Error    = (kind == 2);
    tick();
    bus.i_Tx_Done     = 1'b0;
    bus.i_Tx_Arb_Lost = 1'b0;
    bus.i_Tx_Error    = 1'b0;
  endtask

  task automatic wait_launch(input int bound, output int k);
    bit seen;
    seen = 1'b0;
    k = -1;
    for (int c = 1; c <= bound && !seen; c++) begin
      tick();
      if (bus.o_Tx_DV === 1'b1) begin
        seen = 1'b1;
        k = c;
      end
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    tick();
    tick();
    checks++;
    if ({bus.o_Tx_DV, bus.o_Tx_Id, bus.o_Tx_Dlc, bus.o_Tx_Data, bus.o_Mb_Pending,
         bus.o_Mb_Done, bus.o_Mb_Fail, bus.o_Wr_Err} !== '0) begin
      errors++;
      $display("FAIL reset_outputs: got dv=%b id=%h pend=%b done=%b fail=%b, want all 0",
               bus.o_Tx_DV, bus.o_Tx_Id, bus.o_Mb_Pending, bus.o_Mb_Done, bus.o_Mb_Fail);
    end
    rst = 1'b0;
    tick();
  endtask

  task automatic test_latency();
    int k;
    write_mb(2'd2, 11'h123, 4'd8, 64'h1122334455667788);
    wait_launch(60, k);
    checks++;
    if (k !== 32) begin errors++; $display("FAIL launch_latency: got %0d want 32", k); end
    checks++;
    if (bus.o_Tx_Id !== 11'h123 || bus.o_Tx_Dlc !== 4'd8 || bus.o_Tx_Data !== 64'h1122334455667788) begin
      errors++;
      $display("FAIL launch_fields: got id=%h dlc=%0d data=%h want 123/8/1122334455667788",
               bus.o_Tx_Id, bus.o_Tx_Dlc, bus.o_Tx_Data);
    end
    tick();
    checks++;
    if (bus.o_Tx_DV !== 1'b0) begin errors++; $display("FAIL dv_one_cycle: got %b want 0", bus.o_Tx_DV); end
    outcome(0);
    checks++;
    if (bus.o_Mb_Done !== 4'b0100 || bus.o_Mb_Pending !== 4'b0000) begin
      errors++;
      $display("FAIL done_mb2: got done=%b pend=%b want 0100/0000", bus.o_Mb_Done, bus.o_Mb_Pending);
    end
    tick();
    checks++;
    if (bus.o_Mb_Done !== 4'b0000) begin errors++; $display("FAIL done_pulse_len: got %b want 0000", bus.o_Mb_Done); end
  endtask

  task automatic test_order();
    int k;
    logic [10:0] exp_id   [3];
    logic [63:0] exp_data [3];
    logic [3:0]  exp_done [3];
    exp_id[0] = 11'h100; exp_data[0] = 64'd1; exp_done[0] = 4'b0010;
    exp_id[1] = 11'h100; exp_data[1] = 64'd3; exp_done[1] = 4'b1000;
    exp_id[2] = 11'h200; exp_data[2] = 64'd0; exp_done[2] = 4'b0001;
    write_mb(2'd0, 11'h200, 4'd12, 64'd0);
    write_mb(2'd1, 11'h100, 4'd1, 64'd1);
    write_mb(2'd3, 11'h100, 4'd3, 64'd3);
    for (int n = 0; n < 3; n++) begin
      wait_launch(80, k);
      checks++;
      if (k < 0 || bus.o_Tx_Id !== exp_id[n] || bus.o_Tx_Data !== exp_data[n]) begin
        errors++;
        $display("FAIL order_launch%0d: got k=%0d id=%h data=%h want id=%h data=%h",
                 n, k, bus.o_Tx_Id, bus.o_Tx_Data, exp_id[n], exp_data[n]);
      end
      if (n == 2) begin
        checks++;
        if (bus.o_Tx_Dlc !== 4'd8) begin errors++; $display("FAIL dlc_clamp: got %0d want 8", bus.o_Tx_Dlc); end
      end
      tick();
      outcome(0);
      checks++;
      if (bus.o_Mb_Done !== exp_done[n]) begin
        errors++;
        $display("FAIL order_done%0d: got %b want %b", n, bus.o_Mb_Done, exp_done[n]);
      end
    end
  endtask

  task automatic test_ifs_reload();
    int k;
    int early;
    early = 0;
    write_mb(2'd0, 11'h010, 4'd2, 64'hAB);
    for (int c = 0; c < 27; c++) begin
      tick();
      if (bus.o_Tx_DV === 1'b1) early++;
    end
    bus.i_Bus_Idle = 1'b0;
    for (int c = 0; c < 3; c++) begin
      tick();
      if (bus.o_Tx_DV === 1'b1) early++;
    end
    bus.i_Bus_Idle = 1'b1;
    checks++;
    if (early !== 0) begin errors++; $display("FAIL ifs_early_launch: got %0d launches want 0", early); end
    wait_launch(60, k);
    checks++;
    if (k !== 30) begin errors++; $display("FAIL ifs_reload: got %0d idle cycles want 30", k); end
    tick();
    outcome(0);
    checks++;
    if (bus.o_Mb_Done !== 4'b0001) begin errors++; $display("FAIL ifs_done: got %b want 0001", bus.o_Mb_Done); end
  endtask

  task automatic test_retry();
    int k;
    int launches;
    int bad;
    launches = 0;
    bad = 0;
    write_mb(2'd1, 11'h050, 4'd4, 64'h55);
    for (int n = 1; n <= 8; n++) begin
      wait_launch(80, k);
      if (k > 0) launches++;
      tick();
      outcome(2);
      if (n < 8 && (bus.o_Mb_Fail !== 4'b0000 || bus.o_Mb_Pending !== 4'b0010)) bad++;
    end
    checks++;
    if (launches !== 8 || bad !== 0) begin
      errors++;
      $display("FAIL retry_attempts: got launches=%0d early_fail=%0d want 8/0", launches, bad);
    end
    checks++;
    if (bus.o_Mb_Fail !== 4'b0010 || bus.o_Mb_Pending !== 4'b0000) begin
      errors++;
      $display("FAIL retry_exhausted: got fail=%b pend=%b want 0010/0000", bus.o_Mb_Fail, bus.o_Mb_Pending);
    end
    wait_launch(50, k);
    checks++;
    if (k !== -1) begin errors++; $display("FAIL retry_no_relaunch: got launch at %0d want none", k); end
    launches = 0;
    bad = 0;
    write_mb(2'd1, 11'h050, 4'd4, 64'h55);
    for (int n = 1; n <= 20; n++) begin
      wait_launch(80, k);
      if (k > 0) launches++;
      tick();
      outcome(1);
      if (bus.o_Mb_Fail !== 4'b0000) bad++;
    end
    checks++;
    if (launches !== 20 || bad !== 0 || bus.o_Mb_Pending !== 4'b0010) begin
      errors++;
      $display("FAIL arb_lost_requeue: got launches=%0d fails=%0d pend=%b want 20/0/0010",
               launches, bad, bus.o_Mb_Pending);
    end
    wait_launch(80, k);
    tick();
    outcome(0);
    checks++;
    if (bus.o_Mb_Done !== 4'b0010) begin errors++; $display("FAIL arb_final_done: got %b want 0010", bus.o_Mb_Done); end
  endtask

  task automatic test_abort_pending();
    int k;
    write_mb(2'd2, 11'h010, 4'd1, 64'h2);
    write_mb(2'd3, 11'h300, 4'd1, 64'h3);
    tick();
    tick();
    bus.i_Abort = 4'b1000;
    tick();
    bus.i_Abort = 4'b0000;
    checks++;
    if (bus.o_Mb_Fail !== 4'b1000 || bus.o_Mb_Pending !== 4'b0100) begin
      errors++;
      $display("FAIL abort_pending: got fail=%b pend=%b want 1000/0100", bus.o_Mb_Fail, bus.o_Mb_Pending);
    end
    wait_launch(80, k);
    tick();
    outcome(0);
    checks++;
    if (bus.o_Mb_Done !== 4'b0100) begin errors++; $display("FAIL abort_other_done: got %b want 0100", bus.o_Mb_Done); end
  endtask

  task automatic test_inflight();
    int k;
    write_mb(2'd0, 11'h0AA, 4'd8, 64'hD1D1D1D1D1D1D1D1);
    wait_launch(80, k);
    tick();
    write_mb(2'd0, 11'h001, 4'd2, 64'hD2D2D2D2D2D2D2D2);
    checks++;
    if (bus.o_Wr_Err !== 1'b1 || bus.o_Tx_Data !== 64'hD1D1D1D1D1D1D1D1) begin
      errors++;
      $display("FAIL inflight_write: got wr_err=%b data=%h want 1/d1d1d1d1d1d1d1d1", bus.o_Wr_Err, bus.o_Tx_Data);
    end
    bus.i_Abort = 4'b0001;
    tick();
    bus.i_Abort = 4'b0000;
    checks++;
    if (bus.o_Mb_Fail !== 4'b0000 || bus.o_Mb_Pending !== 4'b0001) begin
      errors++;
      $display("FAIL abort_latched: got fail=%b pend=%b want 0000/0001", bus.o_Mb_Fail, bus.o_Mb_Pending);
    end
    outcome(1);
    checks++;
    if (bus.o_Mb_Fail !== 4'b0001 || bus.o_Mb_Pending !== 4'b0000) begin
      errors++;
      $display("FAIL abort_arb_lost: got fail=%b pend=%b want 0001/0000", bus.o_Mb_Fail, bus.o_Mb_Pending);
    end
    wait_launch(60, k);
    checks++;
    if (k !== -1) begin errors++; $display("FAIL abort_no_relaunch: got launch at %0d want none", k); end
  endtask

  task automatic test_reset_busy();
    int k;
    write_mb(2'd1, 11'h077, 4'd5, 64'hCAFE);
    wait_launch(80, k);
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    checks++;
    if ({bus.o_Tx_DV, bus.o_Tx_Id, bus.o_Tx_Dlc, bus.o_Tx_Data, bus.o_Mb_Pending,
         bus.o_Mb_Done, bus.o_Mb_Fail, bus.o_Wr_Err} !== '0) begin
      errors++;
      $display("FAIL reset_busy: got id=%h data=%h pend=%b want all 0", bus.o_Tx_Id, bus.o_Tx_Data, bus.o_Mb_Pending);
    end
    outcome(0);
    checks++;
    if (bus.o_Mb_Done !== 4'b0000) begin errors++; $display("FAIL done_after_reset: got %b want 0000", bus.o_Mb_Done); end
    wait_launch(50, k);
    checks++;
    if (k !== -1) begin errors++; $display("FAIL launch_after_reset: got launch at %0d want none", k); end
  endtask

  initial begin
    bus.i_Wr_En       = 1'b0;
    bus.i_Wr_Idx      = '0;
    bus.i_Wr_Id       = '0;
    bus.i_Wr_Dlc      = '0;
    bus.i_Wr_Data     = '0;
    bus.i_Abort       = '0;
    bus.i_Bus_Idle    = 1'b1;
    bus.i_Tx_Done     = 1'b0;
    bus.i_Tx_Arb_Lost = 1'b0;
    bus.i_Tx_Error    = 1'b0;
    test_reset();
    test_latency();
    test_order();
    test_ifs_reload();
    test_retry();
    test_abort_pending();
    test_inflight();
    test_reset_busy();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
